psram_dev_resp: RTL and testbench
=================================

Name: psram_dev_resp

Overview:
- Synthesizable octal-DDR PSRAM device responder: the memory-side end of the psram_if bus that the axi4_psram controller drives.
- Runs on the system clock and oversamples psram SCK, CE, IO and DQS/DM.
- Decodes command, address and latency; services linear read, write and mode-register accesses from an internal byte array.
- Used in-bench and on FPGA in place of the encrypted vendor model; clk_i must run at least 4x SCK.

Parameters:
- MEM_AW, 12, byte-address width of the internal array (depth 2**MEM_AW).
- RLAT, 5, read latency in SCK cycles after the last address beat.
- WLAT, 5, write latency in SCK cycles after the last address beat.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- psram_sck_i  in  1  PSRAM clock from controller.
- psram_ce_i  in  1  chip enable, active low.
- psram_io_i  in  8  DQ from pad.
- psram_io_o  out  8  DQ to pad.
- psram_io_en_o  out  8  per-bit pad output enable; 0 drives the pad, matching pad oen_i.
- psram_dqs_i  in  1  DQS/DM from pad; DM during writes.
- psram_dqs_o  out  1  read strobe.
- psram_dqs_en_o  out  1  DQS output enable; 0 drives the pad.

Behaviour:
- Reset values: psram_io_o=0, psram_io_en_o=8'hFF, psram_dqs_o=0, psram_dqs_en_o=1, state=IDLE, MR0..MR3 = 8'h01, 8'h00, 8'h00, 8'h00. Array contents are not reset.
- Input sampling:
  - sck, ce, io and dqs each pass through 2 flops.
  - An edge is a change of synchronized sck between consecutive clk_i cycles.
  - Each rising or falling edge is one beat.
  - io and dqs are captured from the same synchronized stage on the cycle the edge is detected.
- States and transitions:
  - IDLE: synchronized CE falls -> CMD, beat counter = 0.
  - CMD, beats 0-1: beat0 is the opcode; beat1 must equal beat0.
    - Opcodes: 8'h00 read, 8'h80 write, 8'h40 MR read, 8'hC0 MR write.
    - Mismatch or unknown opcode -> IGNORE.
  - ADDR, beats 2-5: 32-bit address, MSB byte first, loaded into addr_q.
  - LAT: lasts 2*RLAT beats (reads) or 2*WLAT beats (memory writes).
    - MR write skips LAT: its data beat directly follows beat 5.
    - MR read uses RLAT.
  - WDATA, one byte per beat:
    - If sampled dqs (DM) = 0, write mem[addr_q[MEM_AW-1:0]].
    - If DM = 1, the byte is masked.
    - addr_q increments on every beat, masked or not.
    - MR write stores only the first data beat into MR[addr_q[1:0]]; later beats are ignored.
  - RDATA:
    - On the edge that ends LAT, in the same cycle: io_en=8'h00, dqs_en=0, io_o = byte0, dqs_o toggles 0->1.
    - Each later edge: io_o = next byte, dqs_o toggles, addr_q increments.
    - MR read returns MR[addr[1:0]] on every beat.
  - IGNORE: no bus drive until CE rises.
- Wrap-around: addr_q increments modulo 2**MEM_AW; no page boundary.
- CE rise, synchronized, in any state:
  - Next cycle -> IDLE, io_en=8'hFF, dqs_en=1, dqs_o=0.
  - A partial write keeps every byte already written.
  - A write with no data beats changes nothing.
- Read data is combinational from the array into the io_o register.
- Latency from detected SCK edge to new io_o/dqs_o: 1 clk_i cycle.
- Async reset mid-transaction releases the bus immediately and returns to IDLE.

Decomposition:
- psram_dev_pkg holds:
  - opcode localparams CMD_RD=8'h00, CMD_WR=8'h80, CMD_MRR=8'h40, CMD_MRW=8'hC0;
  - state enum IDLE/CMD/ADDR/LAT/WDATA/RDATA/IGNORE;
  - ADDR_BEATS=4, MR reset values.
- One sub-module, psram_dev_sync: 2-flop synchronizers for sck/ce/io/dqs, plus a sck edge pulse.
- The array and FSM stay in psram_dev_resp.

Test Plan:
- Write 0x80,0x80, addr 0x00000010, 10 WLAT beats, data 11 22 33 44 with DM=0; then read 0x00,0x00, same addr -> 11 22 33 44 returned, dqs toggling once per byte, io_en=8'h00 only inside RDATA.
- Write at addr 0x00000FFE (MEM_AW=12), 4 bytes AA BB CC DD -> mem[FFE]=AA, mem[FFF]=BB, mem[000]=CC, mem[001]=DD; read-back from FFE wraps identically.
- Write 4 bytes 01 02 03 04 at 0x20 with DM=1 on beat 1 over prior 00 FF 00 FF -> read gives 01 FF 03 04.
- MR write 0xC0,0xC0, addr 0x00000002, data 8'h5A -> MR read 0x40,0x40, addr 0x2 returns 5A on every beat; MR0 still reads 01.
- Opcode beats 0x00,0x80 mismatch -> IGNORE; no bus drive for the whole CE-low window; the array is unchanged.
- CE raised after read beat 2 -> io_en=8'hFF and dqs_en=1 within 3 clk_i cycles; the next read at the same address starts cleanly from byte0.

Source files
------------

// File: rtl/psram_dev_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psram_dev_pkg
// Brief    : Opcodes, FSM state encoding and reset constants for psram_dev_resp
// Revision : 1.0
// ============================================================================
package psram_dev_pkg;

    localparam logic [7:0] CMD_RD  = 8'h00;
    localparam logic [7:0] CMD_WR  = 8'h80;
    localparam logic [7:0] CMD_MRR = 8'h40;
    localparam logic [7:0] CMD_MRW = 8'hC0;

    localparam int ADDR_BEATS = 4;

    // Element i is the reset value of MRi.
    localparam logic [3:0][7:0] MR_RST = {8'h00, 8'h00, 8'h00, 8'h01};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        LAT    = 3'd3,
        WDATA  = 3'd4,
        RDATA  = 3'd5,
        IGNORE = 3'd6
    } state_e;

    function automatic logic op_known(input logic [7:0] op);
        return (op == CMD_RD) || (op == CMD_WR) || (op == CMD_MRR) || (op == CMD_MRW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/psram_dev_sync.sv
`default_nettype none
// ============================================================================
// Module   : psram_dev_sync
// Brief    : 2-flop synchronizers for SCK/CE/IO/DQS plus SCK edge and CE edges
// Revision : 1.0
// ============================================================================
module psram_dev_sync (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       i_sck,
    input  logic       i_ce_n,
    input  logic [7:0] i_io,
    input  logic       i_dqs,
    output logic       o_sck_edge,
    output logic       o_ce_fall,
    output logic       o_ce_rise,
    output logic [7:0] o_io,
    output logic       o_dqs
);

    logic       r_sck_meta, r_sck_sync, r_sck_prev;
    logic       r_ce_meta,  r_ce_sync,  r_ce_prev;
    logic [7:0] r_io_meta,  r_io_sync;
    logic       r_dqs_meta, r_dqs_sync;

    // CE resets deasserted so a released reset does not fake a CE fall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sck_meta <= 1'b0;
            r_sck_sync <= 1'b0;
            r_sck_prev <= 1'b0;
            r_ce_meta  <= 1'b1;
            r_ce_sync  <= 1'b1;
            r_ce_prev  <= 1'b1;
            r_io_meta  <= 8'h00;
            r_io_sync  <= 8'h00;
            r_dqs_meta <= 1'b0;
            r_dqs_sync <= 1'b0;
        end else begin
            r_sck_meta <= i_sck;
            r_sck_sync <= r_sck_meta;
            r_sck_prev <= r_sck_sync;
            r_ce_meta  <= i_ce_n;
            r_ce_sync  <= r_ce_meta;
            r_ce_prev  <= r_ce_sync;
            r_io_meta  <= i_io;
            r_io_sync  <= r_io_meta;
            r_dqs_meta <= i_dqs;
            r_dqs_sync <= r_dqs_meta;
        end
    end

    assign o_sck_edge = r_sck_sync ^ r_sck_prev;
    assign o_ce_fall  = r_ce_prev & ~r_ce_sync;
    assign o_ce_rise  = ~r_ce_prev & r_ce_sync;
    assign o_io       = r_io_sync;
    assign o_dqs      = r_dqs_sync;

endmodule
`default_nettype wire

// File: rtl/psram_dev_resp.sv
`default_nettype none
// ============================================================================
// Module   : psram_dev_resp
// Brief    : Octal-DDR PSRAM device responder with internal byte array and MRs
// Revision : 1.0
// ============================================================================
module psram_dev_resp
    import psram_dev_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int RLAT   = 5,
    parameter int WLAT   = 5
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [7:0] psram_io_i,
    output logic [7:0] psram_io_o,
    output logic [7:0] psram_io_en_o,
    input  logic       psram_dqs_i,
    output logic       psram_dqs_o,
    output logic       psram_dqs_en_o
);

    // Latencies are counted as the index of the last LAT beat (RLAT, WLAT >= 1).
    localparam logic [7:0] c_rd_lat_last = 8'(2 * RLAT - 1);
    localparam logic [7:0] c_wr_lat_last = 8'(2 * WLAT - 1);
    localparam logic [7:0] c_addr_last   = 8'(ADDR_BEATS - 1);

    logic              w_sck_edge, w_ce_fall, w_ce_rise, w_dm;
    logic [7:0]        w_io;

    state_e            r_state, w_state_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [7:0]        r_op, w_op_nxt;
    logic [MEM_AW-1:0] r_addr, w_addr_nxt, w_addr_inc;
    logic              r_mr_done, w_mr_done_nxt;
    logic [7:0]        r_io_o, w_io_o_nxt;
    logic [7:0]        r_io_en, w_io_en_nxt;
    logic              r_dqs_o, w_dqs_o_nxt;
    logic              r_dqs_en, w_dqs_en_nxt;
    logic [3:0][7:0]   r_mr;
    logic [7:0]        r_mem [2**MEM_AW];
    logic              w_mem_we, w_mr_we, w_is_read;
    logic [7:0]        w_lat_last, w_rd_first, w_rd_next;

    psram_dev_sync u_sync (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_sck      (psram_sck_i),
        .i_ce_n     (psram_ce_i),
        .i_io       (psram_io_i),
        .i_dqs      (psram_dqs_i),
        .o_sck_edge (w_sck_edge),
        .o_ce_fall  (w_ce_fall),
        .o_ce_rise  (w_ce_rise),
        .o_io       (w_io),
        .o_dqs      (w_dm)
    );

    assign w_is_read  = (r_op == CMD_RD) || (r_op == CMD_MRR);
    assign w_lat_last = w_is_read ? c_rd_lat_last : c_wr_lat_last;
    assign w_addr_inc = r_addr + MEM_AW'(1);
    assign w_rd_first = (r_op == CMD_MRR) ? r_mr[r_addr[1:0]] : r_mem[r_addr];
    assign w_rd_next  = (r_op == CMD_MRR) ? r_mr[r_addr[1:0]] : r_mem[w_addr_inc];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_ce_rise) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_ce_fall) w_state_nxt = CMD;
                CMD:     if (w_sck_edge && r_cnt == 8'd1)
                             w_state_nxt = (w_io == r_op && op_known(r_op)) ? ADDR : IGNORE;
                ADDR:    if (w_sck_edge && r_cnt == c_addr_last)
                             w_state_nxt = (r_op == CMD_MRW) ? WDATA : LAT;
                LAT:     if (w_sck_edge && r_cnt == w_lat_last)
                             w_state_nxt = w_is_read ? RDATA : WDATA;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_io_o_nxt    = r_io_o;
        w_io_en_nxt   = r_io_en;
        w_dqs_o_nxt   = r_dqs_o;
        w_dqs_en_nxt  = r_dqs_en;
        w_cnt_nxt     = r_cnt;
        w_op_nxt      = r_op;
        w_addr_nxt    = r_addr;
        w_mr_done_nxt = r_mr_done;
        w_mem_we      = 1'b0;
        w_mr_we       = 1'b0;
        if (w_ce_rise) begin
            w_io_en_nxt  = 8'hFF;
            w_dqs_en_nxt = 1'b1;
            w_dqs_o_nxt  = 1'b0;
            w_cnt_nxt    = 8'd0;
        end else begin
            case (r_state)
                IDLE: if (w_ce_fall) begin
                    w_cnt_nxt     = 8'd0;
                    w_mr_done_nxt = 1'b0;
                end
                CMD: if (w_sck_edge) begin
                    if (r_cnt == 8'd0) begin
                        w_op_nxt  = w_io;
                        w_cnt_nxt = 8'd1;
                    end else begin
                        w_cnt_nxt = 8'd0;
                    end
                end
                // Only the low MEM_AW address bits can reach the array.
                ADDR: if (w_sck_edge) begin
                    w_addr_nxt = MEM_AW'({r_addr, w_io});
                    w_cnt_nxt  = (r_cnt == c_addr_last) ? 8'd0 : r_cnt + 8'd1;
                end
                LAT: if (w_sck_edge) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == w_lat_last && w_is_read) begin
                        w_io_o_nxt   = w_rd_first;
                        w_io_en_nxt  = 8'h00;
                        w_dqs_en_nxt = 1'b0;
                        w_dqs_o_nxt  = 1'b1;
                    end
                end
                WDATA: if (w_sck_edge) begin
                    if (r_op == CMD_MRW) begin
                        w_mr_we       = ~r_mr_done;
                        w_mr_done_nxt = 1'b1;
                    end else begin
                        w_mem_we   = ~w_dm;
                        w_addr_nxt = w_addr_inc;
                    end
                end
                RDATA: if (w_sck_edge) begin
                    w_dqs_o_nxt = ~r_dqs_o;
                    w_io_o_nxt  = w_rd_next;
                    if (r_op != CMD_MRR) w_addr_nxt = w_addr_inc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt     <= 8'd0;
            r_op      <= 8'd0;
            r_addr    <= '0;
            r_mr_done <= 1'b0;
            r_io_o    <= 8'h00;
            r_io_en   <= 8'hFF;
            r_dqs_o   <= 1'b0;
            r_dqs_en  <= 1'b1;
            r_mr      <= MR_RST;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_op      <= w_op_nxt;
            r_addr    <= w_addr_nxt;
            r_mr_done <= w_mr_done_nxt;
            r_io_o    <= w_io_o_nxt;
            r_io_en   <= w_io_en_nxt;
            r_dqs_o   <= w_dqs_o_nxt;
            r_dqs_en  <= w_dqs_en_nxt;
            if (w_mr_we) r_mr[r_addr[1:0]] <= w_io;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_we) r_mem[r_addr] <= w_io;
    end

    assign psram_io_o     = r_io_o;
    assign psram_io_en_o  = r_io_en;
    assign psram_dqs_o    = r_dqs_o;
    assign psram_dqs_en_o = r_dqs_en;

endmodule
`default_nettype wire

// File: tb/tb_psram_dev_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_dev_resp
// Brief    : Self-checking bench for psram_dev_resp (vector table + scoreboard)
// Revision : 1.0
// ============================================================================
module tb_psram_dev_resp;
    import psram_dev_pkg::*;

    localparam int RLAT = 5;
    localparam int WLAT = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck, ce_n, dqs_in;
    logic [7:0] io_in;
    logic [7:0] io_o, io_en;
    logic       dqs_o, dqs_en;

    psram_dev_resp #(.MEM_AW(12), .RLAT(RLAT), .WLAT(WLAT)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .psram_sck_i    (sck),
        .psram_ce_i     (ce_n),
        .psram_io_i     (io_in),
        .psram_io_o     (io_o),
        .psram_io_en_o  (io_en),
        .psram_dqs_i    (dqs_in),
        .psram_dqs_o    (dqs_o),
        .psram_dqs_en_o (dqs_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        int          n;
        logic [31:0] data;
        logic [3:0]  dm;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       dqs;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[14];
    int   n_vec = 0;
    int   n_err = 0;
    int   drive_seen = 0;
    bit   mon_on = 1'b0;

    always @(posedge clk) begin
        if (mon_on && (io_en !== 8'hFF || dqs_en !== 1'b1)) drive_seen <= drive_seen + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic m);
        io_in  = d;
        dqs_in = m;
        repeat (2) @(posedge clk);
        #1 sck = ~sck;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic sb_pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("rd_beat", {14'd0, io_o, dqs_o, io_en, dqs_en},
                  {14'd0, e.data, e.dqs, 8'h00, 1'b0});
        end
    endtask

    task automatic ce_release_check();
        ce_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("ce_release", {22'd0, io_en, dqs_en, dqs_o}, {22'd0, 8'hFF, 1'b1, 1'b0});
    endtask

    task automatic do_txn(input vec_t v);
        int   lat;
        bit   rd;
        exp_t e;
        rd  = (v.op == CMD_RD) || (v.op == CMD_MRR);
        lat = (v.op == CMD_MRW) ? 0 : (rd ? 2 * RLAT : 2 * WLAT);
        drive_seen = 0;
        mon_on = !rd;
        ce_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        beat(v.op, 1'b0);
        beat(v.op, 1'b0);
        for (int i = 0; i < 4; i++) beat(v.addr[31-8*i -: 8], 1'b0);
        if (rd) begin
            for (int i = 0; i < v.n; i++) begin
                e.data = v.data[31-8*i -: 8];
                e.dqs  = (i % 2 == 0);
                sb_q.push_back(e);
            end
            for (int i = 0; i < lat - 1; i++) begin
                beat(8'h00, 1'b0);
                check("lat_no_drive", {23'd0, io_en, dqs_en}, {23'd0, 8'hFF, 1'b1});
            end
            beat(8'h00, 1'b0);
            sb_pop_check();
            for (int i = 1; i < v.n; i++) begin
                beat(8'h00, 1'b0);
                sb_pop_check();
            end
        end else begin
            for (int i = 0; i < lat; i++) beat(8'h00, 1'b0);
            for (int i = 0; i < v.n; i++) beat(v.data[31-8*i -: 8], v.dm[i]);
        end
        ce_release_check();
        if (!rd) check("wr_no_drive", drive_seen, 0);
        mon_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        tbl[0]  = '{CMD_WR,  32'h0000_0010, 4, 32'h1122_3344, 4'b0000};
        tbl[1]  = '{CMD_RD,  32'h0000_0010, 4, 32'h1122_3344, 4'b0000};
        tbl[2]  = '{CMD_WR,  32'h0000_0FFE, 4, 32'hAABB_CCDD, 4'b0000};
        tbl[3]  = '{CMD_RD,  32'h0000_0FFE, 4, 32'hAABB_CCDD, 4'b0000};
        tbl[4]  = '{CMD_RD,  32'h0000_0000, 2, 32'hCCDD_0000, 4'b0000};
        tbl[5]  = '{CMD_WR,  32'h0000_0020, 4, 32'h00FF_00FF, 4'b0000};
        tbl[6]  = '{CMD_WR,  32'h0000_0020, 4, 32'h0102_0304, 4'b0010};
        tbl[7]  = '{CMD_RD,  32'h0000_0020, 4, 32'h01FF_0304, 4'b0000};
        tbl[8]  = '{CMD_MRW, 32'h0000_0002, 2, 32'h5A77_0000, 4'b0000};
        tbl[9]  = '{CMD_MRR, 32'h0000_0002, 4, 32'h5A5A_5A5A, 4'b0000};
        tbl[10] = '{CMD_MRR, 32'h0000_0000, 2, 32'h0101_0000, 4'b0000};
        tbl[11] = '{CMD_MRR, 32'h0000_0001, 2, 32'h0000_0000, 4'b0000};
        tbl[12] = '{CMD_RD,  32'h0000_0010, 2, 32'h1122_0000, 4'b0000};
        tbl[13] = '{CMD_RD,  32'h0000_0010, 4, 32'h1122_3344, 4'b0000};

        rst_n  = 1'b0;
        sck    = 1'b0;
        ce_n   = 1'b1;
        io_in  = 8'h00;
        dqs_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {15'd0, io_o, io_en, dqs_o, dqs_en},
                 {15'd0, 8'h00, 8'hFF, 1'b0, 1'b1});
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) do_txn(tbl[i]);

        // Opcode beats disagree: the device must stay off the bus and not write.
        drive_seen = 0;
        mon_on = 1'b1;
        ce_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        beat(8'h00, 1'b0);
        beat(8'h80, 1'b0);
        beat(8'h00, 1'b0);
        beat(8'h00, 1'b0);
        beat(8'h00, 1'b0);
        beat(8'h10, 1'b0);
        for (int i = 0; i < 2 * WLAT; i++) beat(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) beat(8'h99, 1'b0);
        ce_release_check();
        check("ignore_no_drive", drive_seen, 0);
        mon_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v = '{CMD_RD, 32'h0000_0010, 4, 32'h1122_3344, 4'b0000};
        do_txn(v);

        // Async reset while the device is driving read data.
        ce_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        beat(CMD_RD, 1'b0);
        beat(CMD_RD, 1'b0);
        for (int i = 0; i < 3; i++) beat(8'h00, 1'b0);
        beat(8'h10, 1'b0);
        for (int i = 0; i < 2 * RLAT; i++) beat(8'h00, 1'b0);
        check("rst_pre_drive", {23'd0, io_en, dqs_en}, {23'd0, 8'h00, 1'b0});
        #2 rst_n = 1'b0;
        #1 check("rst_release", {22'd0, io_en, dqs_en, dqs_o}, {22'd0, 8'hFF, 1'b1, 1'b0});
        ce_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        v = '{CMD_RD, 32'h0000_0010, 4, 32'h1122_3344, 4'b0000};
        do_txn(v);
        v = '{CMD_MRR, 32'h0000_0002, 2, 32'h0000_0000, 4'b0000};
        do_txn(v);

        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
